// File: rtl/ledr_pwm_blink_driver.sv
// LEDR pin driver: frame-aligned global PWM dimming and whole-bank blinking.
// Pattern, duty and blink settings are latched only at PWM frame boundaries.
module ledr_pwm_blink_driver #(
    parameter int NUM_LEDS   = 10,
    parameter int PWM_BITS   = 4,
    parameter int PRESCALE   = 50,
    parameter int BLINK_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_LEDS-1:0]   led_value,
    input  logic [PWM_BITS-1:0]   duty,
    input  logic                  blink_en,
    input  logic [BLINK_BITS-1:0] blink_half_period,
    output logic [NUM_LEDS-1:0]   ledr,
    output logic                  frame_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [NUM_LEDS-1:0]   led_q;
    logic [PWM_BITS-1:0]   duty_q;
    logic                  blink_en_q;
    logic [BLINK_BITS-1:0] half_q;

    logic [NUM_LEDS-1:0]   led_f;
    logic [PWM_BITS-1:0]   duty_f;
    logic                  blink_en_f;
    logic [BLINK_BITS-1:0] half_f;

    logic [PW-1:0]         presc;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [BLINK_BITS-1:0] bcnt;
    logic                  blink_phase;

    logic                  tick;
    logic                  frame_wrap;
    logic                  pwm_on;
    logic [BLINK_BITS-1:0] half_last;

    assign tick       = (presc == PW'(PRESCALE - 1));
    assign frame_wrap = tick && (pwm_cnt == '1);
    assign pwm_on     = (duty_f == '1) ? 1'b1 : (pwm_cnt < duty_f);
    // A half-period of 0 behaves like 1: toggle every frame.
    assign half_last  = (half_f == '0) ? '0 : half_f - 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q      <= '0;
            duty_q     <= '0;
            blink_en_q <= 1'b0;
            half_q     <= '0;
        end else begin
            led_q      <= led_value;
            duty_q     <= duty;
            blink_en_q <= blink_en;
            half_q     <= blink_half_period;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            presc       <= tick ? '0 : presc + PW'(1);
            frame_start <= frame_wrap;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_f      <= '0;
            duty_f     <= '0;
            blink_en_f <= 1'b0;
            half_f     <= '0;
        end else if (frame_wrap) begin
            led_f      <= led_q;
            duty_f     <= duty_q;
            blink_en_f <= blink_en_q;
            half_f     <= half_q;
        end
    end

    // Entering or leaving blink mode restarts with a full on-phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt        <= '0;
            blink_phase <= 1'b1;
        end else if (frame_wrap) begin
            if (!blink_en_q || !blink_en_f) begin
                bcnt        <= '0;
                blink_phase <= 1'b1;
            end else if (bcnt == half_last) begin
                bcnt        <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ledr <= '0;
        end else begin
            ledr <= led_f & {NUM_LEDS{pwm_on & blink_phase}};
        end
    end

endmodule

// File: tb/tb_ledr_pwm_blink_driver.sv
// Self-checking bench for ledr_pwm_blink_driver: frame-level reference model
// driven by cycle count since reset release, with directed and random steps.
module tb_ledr_pwm_blink_driver;

    localparam int P     = 2;
    localparam int FRAME = 16 * P;

    logic        clk;
    logic        reset_n;
    logic [9:0]  led_value;
    logic [3:0]  duty;
    logic        blink_en;
    logic [15:0] blink_half_period;
    logic [9:0]  ledr;
    logic        frame_start;

    int n_tests;
    int n_fail;

    int          n;
    logic [9:0]  m_led;
    int          m_duty;
    logic        m_ben;
    int          m_half;
    logic        m_phase;
    int          m_el;
    logic [9:0]  q_led;
    int          q_duty;
    logic        q_ben;
    int          q_half;

    ledr_pwm_blink_driver #(
        .NUM_LEDS(10),
        .PWM_BITS(4),
        .PRESCALE(P),
        .BLINK_BITS(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .led_value(led_value),
        .duty(duty),
        .blink_en(blink_en),
        .blink_half_period(blink_half_period),
        .ledr(ledr),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        n       = 0;
        m_led   = '0;
        m_duty  = 0;
        m_ben   = 1'b0;
        m_half  = 0;
        m_phase = 1'b1;
        m_el    = 0;
        q_led   = '0;
        q_duty  = 0;
        q_ben   = 1'b0;
        q_half  = 0;
    endtask

    task automatic check(input string tag, input logic [9:0] obs,
                         input logic [9:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    // One clock edge: predict outputs from the frame state before the edge,
    // then advance the frame-level state if this edge closes a frame.
    task automatic step();
        logic [9:0] exp_led;
        logic       exp_fs;
        logic       on;
        int         pos;
        int         hl;
        @(posedge clk);
        n++;
        pos     = ((n - 1) / P) % 16;
        on      = (m_duty == 15) ? 1'b1 : (pos < m_duty);
        exp_led = m_led & {10{on & m_phase}};
        exp_fs  = (n % FRAME == 0);
        if (n % FRAME == 0) begin
            if (!q_ben || !m_ben) begin
                m_phase = 1'b1;
                m_el    = 0;
            end else begin
                hl = (m_half == 0) ? 1 : m_half;
                m_el++;
                if (m_el == hl) begin
                    m_el    = 0;
                    m_phase = !m_phase;
                end
            end
            m_led  = q_led;
            m_duty = q_duty;
            m_ben  = q_ben;
            m_half = q_half;
        end
        q_led  = led_value;
        q_duty = int'(duty);
        q_ben  = blink_en;
        q_half = int'(blink_half_period);
        #1;
        check("ledr", ledr, exp_led);
        check("frame_start", {9'd0, frame_start}, {9'd0, exp_fs});
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic drive(input logic [9:0] l, input logic [3:0] d,
                         input logic b, input logic [15:0] h);
        led_value         = l;
        duty              = d;
        blink_en          = b;
        blink_half_period = h;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_ledr", ledr, 10'h000);
        check("rst_fs", {9'd0, frame_start}, 10'h000);
        repeat (3) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        reset_n = 1'b0;
        drive(10'h3FF, 4'hF, 1'b0, 16'd0);
        repeat (2) @(negedge clk);
        #1;
        check("por_ledr", ledr, 10'h000);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;

        // First frame after reset stays dark, then full pattern.
        run(3 * FRAME);
        check("steady_3ff", ledr, 10'h3FF);

        // Duty sweep.
        drive(10'h155, 4'd4, 1'b0, 16'd0);
        run(3 * FRAME);
        drive(10'h155, 4'd0, 1'b0, 16'd0);
        run(2 * FRAME);
        drive(10'h155, 4'd15, 1'b0, 16'd0);
        run(2 * FRAME);

        // Mid-frame pattern change.
        drive(10'h001, 4'hF, 1'b0, 16'd0);
        run(2 * FRAME);
        while (n % FRAME != 5 * P) step();
        drive(10'h200, 4'hF, 1'b0, 16'd0);
        run(2 * FRAME);

        // Blink with half=3, then half=0.
        drive(10'h2AA, 4'hF, 1'b1, 16'd3);
        run(10 * FRAME);
        drive(10'h2AA, 4'hF, 1'b0, 16'd0);
        run(2 * FRAME);
        drive(10'h2AA, 4'hF, 1'b1, 16'd0);
        run(5 * FRAME);

        // Disable blink while in the off phase, then re-enable.
        drive(10'h0F0, 4'hF, 1'b0, 16'd2);
        run(2 * FRAME);
        drive(10'h0F0, 4'hF, 1'b1, 16'd2);
        for (int i = 0; i < 10 * FRAME && m_phase; i++) step();
        check("phase_off_reached", {9'd0, m_phase}, 10'h000);
        run(3);
        drive(10'h0F0, 4'hF, 1'b0, 16'd2);
        run(3 * FRAME);
        drive(10'h0F0, 4'hF, 1'b1, 16'd2);
        run(6 * FRAME);

        // Randomized segments; half-period only changes with blink off.
        for (int s = 0; s < 40; s++) begin
            logic       b;
            logic [15:0] h;
            b = 1'($urandom_range(0, 1));
            h = b ? blink_half_period : 16'($urandom_range(0, 3));
            drive(10'($urandom), 4'($urandom), b, h);
            run($urandom_range(1, 3 * FRAME));
        end

        // Async reset mid-frame while fully lit.
        drive(10'h3FF, 4'hF, 1'b0, 16'd0);
        run(3 * FRAME);
        while (n % FRAME != 7 * P) step();
        check("pre_reset_ledr", ledr, 10'h3FF);
        do_reset();
        run(3 * FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ledr_pwm_blink_driver.md
Name: ledr_pwm_blink_driver

Overview:
Downstream stage of the LEDR parallel output port. It takes the port's 10-bit LED pattern and drives the physical LEDR pins. Each lit LED gets global PWM brightness dimming and optional whole-bank blinking. All pattern, duty and blink-enable changes are frame-aligned, so pins never glitch mid-frame.

Parameters:
NUM_LEDS, 10, width of LED pattern and pin bus
PWM_BITS, 4, PWM counter/duty width; frame = 2^PWM_BITS ticks
PRESCALE, 50, clk cycles per PWM tick (>=1)
BLINK_BITS, 16, width of blink half-period (in PWM frames)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
led_value  in  NUM_LEDS  LED pattern from the PIO output port, clk domain
duty  in  PWM_BITS  global brightness; 0 = off, all-ones = fully on
blink_en  in  1  1 = blink the bank, 0 = steady
blink_half_period  in  BLINK_BITS  frames per blink on/off phase; 0 treated as 1
ledr  out  NUM_LEDS  registered LED pin drive, 1 = lit
frame_start  out  1  one-cycle pulse at each PWM frame boundary

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk. On reset, all counters = 0, shadow registers = 0, blink_phase = 1, ledr = 0, frame_start = 0.
- Input stage: led_value, duty, blink_en and blink_half_period are registered every clk into *_q (1 cycle).
- Prescaler:
  - presc counts 0..PRESCALE-1, then wraps.
  - tick = (presc == PRESCALE-1).
  - PRESCALE=1 gives tick every cycle.
- PWM counter: pwm_cnt increments on tick and wraps from 2^PWM_BITS-1 to 0.
- Frame boundary:
  - frame_wrap = tick && pwm_cnt == 2^PWM_BITS-1.
  - Cycle after frame_wrap: frame_start = 1 for exactly one cycle.
  - On frame_wrap, shadow registers load from the *_q values: led_f, duty_f, blink_en_f, half_f.
  - The shadow registers hold for the whole frame. Mid-frame input changes never reach ledr.
- PWM compare:
  - pwm_on = (duty_f == all-ones) ? 1 : (pwm_cnt < duty_f).
  - duty_f = 0 gives constant off.
  - duty_f = k (0<k<max) gives k ticks on per frame, at the start of the frame.
- Blink:
  - If blink_en_f = 0: blink_phase forced to 1, frame counter bcnt held at 0.
  - Else on each frame_wrap, bcnt increments.
  - When bcnt reaches max(half_f,1)-1 on a frame_wrap, bcnt resets to 0 and blink_phase toggles.
  - blink_en 1->0 (at a frame boundary) restores blink_phase = 1 immediately in that frame.
  - blink_en 0->1 starts with phase on and a full half-period.
- Output: ledr <= led_f & {NUM_LEDS{pwm_on & blink_phase}}, registered. pwm_cnt to ledr latency = 1 cycle.
- Worst-case latency from led_value change to ledr: 1 (input reg) + up to one frame (PRESCALE*2^PWM_BITS cycles) + 1 (output reg).
- Simultaneous events: an input change in the same cycle as frame_wrap is not captured (the *_q register is one cycle behind) and applies at the next frame.
- Reset mid-operation: reset asserted mid-frame forces ledr = 0 asynchronously. After release, counting restarts from presc = 0, pwm_cnt = 0. The first frame_wrap occurs PRESCALE*2^PWM_BITS cycles after release, and ledr stays 0 until then (shadow = 0).
- Combinational loops: none. All outputs come from flops.

Test Plan:
- Reset, PRESCALE=2: led_value=0x3FF, duty=0xF, blink_en=0 from time 0 -> ledr=0 until the first frame_wrap (cycle 32 after release). ledr=0x3FF from cycle 33 onward, constant; frame_start pulses every 32 cycles.
- Duty sweep, PRESCALE=1: led_value=0x155, duty=4 -> each 16-cycle frame shows ledr=0x155 for 4 cycles, then 0 for 12. duty=0 -> ledr=0 for the whole frame.
- Mid-frame change: change led_value 0x001->0x200 at tick 5 of a frame -> ledr keeps 0x001 pattern until the frame ends, then shows 0x200 one cycle after frame_start. No partial-frame glitch.
- Blink, PRESCALE=1: duty=0xF, blink_en=1, half=3 -> ledr=pattern for 3 frames (48 cycles), then 0 for 48, repeating. half=0 -> toggles every frame (16 cycles).
- Blink disable: blink_en drops while phase is off -> at the next frame boundary ledr returns to the pattern and bcnt=0. Re-enable -> full on-phase of half frames.
- Async reset mid-frame with ledr=0x3FF -> ledr=0 within the reset cycle (no clk edge needed). After release, the first-frame behaviour matches scenario 1.
